// File: rtl/cacheline_burst_adaptor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cacheline_burst_pkg: default widths and FSM state codes for the line adaptor
// Rev 1.0
// ----------------------------------------------------------------------------
package cacheline_burst_pkg;

   localparam int DEF_BEAT_W = 64;
   localparam int DEF_BEATS  = 4;
   localparam int DEF_LINE_W = 256;
   localparam int DEF_ADDR_W = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_RD_BURST = 2'd1;
   localparam state_t ST_WR_BURST = 2'd2;
   localparam state_t ST_DONE     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cacheline_burst_adaptor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cacheline_burst_adaptor_if: cache-side line port plus narrow burst port
// Rev 1.0
// ----------------------------------------------------------------------------
interface cacheline_burst_adaptor_if
   import cacheline_burst_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int LINE_W = DEF_LINE_W
);

   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   logic [ADDR_W-1:0] burst_address;
   logic              burst_read;
   logic              burst_write;
   logic [BEAT_W-1:0] burst_wdata;
   logic [BEAT_W-1:0] burst_rdata;
   logic              burst_resp;

   // slave is the adaptor; master is the cache plus memory environment
   modport slave (
      input  pmem_address, pmem_wdata, pmem_read, pmem_write, burst_rdata, burst_resp,
      output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
   );

   modport master (
      output pmem_address, pmem_wdata, pmem_read, pmem_write, burst_rdata, burst_resp,
      input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
   );

endinterface
`default_nettype wire

// File: rtl/cacheline_burst_adaptor_line_beat_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_beat_buffer: read line assembled beat by beat, write line sliced out
// Rev 1.0
// ----------------------------------------------------------------------------
module line_beat_buffer
   import cacheline_burst_pkg::*;
#(
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS,
   parameter int LINE_W = DEF_LINE_W,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              line_we,
   input  logic [LINE_W-1:0] line_in,
   input  logic              beat_we,
   input  logic [IDX_W-1:0]  beat_idx,
   input  logic [BEAT_W-1:0] beat_in,
   input  logic [IDX_W-1:0]  store_idx,
   output logic [BEAT_W-1:0] store_beat,
   output logic [LINE_W-1:0] rd_line
);

   // Separate registers so a writeback never disturbs the last read line
   logic [LINE_W-1:0] rd_line_q, rd_line_d;
   logic [LINE_W-1:0] wr_line_q, wr_line_d;

   always_comb begin
      rd_line_d = rd_line_q;
      wr_line_d = wr_line_q;
      if (beat_we) begin
         rd_line_d[beat_idx*BEAT_W +: BEAT_W] = beat_in;
      end
      if (line_we) begin
         wr_line_d = line_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_line_q <= '0;
         wr_line_q <= '0;
      end else begin
         rd_line_q <= rd_line_d;
         wr_line_q <= wr_line_d;
      end
   end

   assign store_beat = wr_line_q[store_idx*BEAT_W +: BEAT_W];
   assign rd_line    = rd_line_q;

endmodule
`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cacheline_burst_adaptor: turns cache line reads/writes into BEATS-beat bursts
// Rev 1.0
// ----------------------------------------------------------------------------
module cacheline_burst_adaptor
   import cacheline_burst_pkg::*;
#(
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS,
   parameter int LINE_W = DEF_LINE_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   cacheline_burst_adaptor_if.slave  bus
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

   if (LINE_W != BEAT_W * BEATS) begin : g_width_check
      $error("LINE_W must equal BEAT_W*BEATS");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              line_we;
   logic              beat_we;
   logic [BEAT_W-1:0] store_beat;
   logic [ADDR_W-1:0] aligned_addr;

   assign aligned_addr = bus.pmem_address & ~OFF_MASK;

   // Write is checked first so a dirty writeback precedes the refill
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      line_we = 1'b0;
      beat_we = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.pmem_write) begin
               addr_d  = aligned_addr;
               line_we = 1'b1;
               state_d = ST_WR_BURST;
            end else if (bus.pmem_read) begin
               addr_d  = aligned_addr;
               state_d = ST_RD_BURST;
            end
         end
         ST_RD_BURST, ST_WR_BURST: begin
            if (bus.burst_resp) begin
               beat_we = (state_q == ST_RD_BURST);
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   line_beat_buffer #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS),
      .LINE_W (LINE_W),
      .IDX_W  (CNT_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .line_we    (line_we),
      .line_in    (bus.pmem_wdata),
      .beat_we    (beat_we),
      .beat_idx   (cnt_q),
      .beat_in    (bus.burst_rdata),
      .store_idx  (cnt_q),
      .store_beat (store_beat),
      .rd_line    (bus.pmem_rdata)
   );

   assign bus.burst_address = addr_q;
   assign bus.burst_read    = (state_q == ST_RD_BURST);
   assign bus.burst_write   = (state_q == ST_WR_BURST);
   assign bus.burst_wdata   = (state_q == ST_WR_BURST) ? store_beat : '0;
   assign bus.pmem_resp     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cacheline_burst_adaptor: randomized line transfers against a line-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cacheline_burst_adaptor;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [255:0] last_rline;

   always #5 clk = ~clk;

   cacheline_burst_adaptor_if bif ();

   cacheline_burst_adaptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [31:0] line_align(input logic [31:0] a);
      return (a / 32) * 32;
   endfunction

   // Plays the memory side: first beat one cycle after the strobe, then 'gap' idle cycles between beats
   task automatic run_burst(input bit is_wr, input logic [31:0] exp_addr, input logic [255:0] line,
                            input int gap, input int lead, input bit chk_hold,
                            input logic [255:0] hold_val, input int exp_lat, input bit scramble);
      int   tk = 0;
      int   beats = 0;
      int   w = 1;
      int   last_drv = -10;
      bit   done = 0;
      logic strobe, other;
      while (!done && tk < 300) begin
         tick();
         tk++;
         if (bif.burst_resp) begin
            beats++;
            last_drv = tk - 1;
         end
         bif.burst_resp = 1'b0;
         if (scramble) begin
            bif.pmem_address = $urandom;
            bif.pmem_wdata   = rand256();
         end
         if (tk <= lead) begin
            total++;
            if (bif.burst_read !== 1'b0 || bif.burst_write !== 1'b0 || bif.pmem_resp !== 1'b0) begin
               bad++;
               $display("FAIL lead_idle: rd=%b wr=%b resp=%b want 0 0 0",
                        bif.burst_read, bif.burst_write, bif.pmem_resp);
            end
         end else if (bif.pmem_resp === 1'b1) begin
            done = 1;
            total++;
            if (beats != 4) begin
               bad++;
               $display("FAIL beat_count: got %0d want 4", beats);
            end
            total++;
            if (tk != last_drv + 1) begin
               bad++;
               $display("FAIL resp_latency: resp at tick %0d, last beat at %0d, want +1", tk, last_drv);
            end
            if (exp_lat > 0) begin
               total++;
               if (tk != exp_lat) begin
                  bad++;
                  $display("FAIL total_latency: got %0d want %0d", tk, exp_lat);
               end
            end
            total++;
            if (bif.burst_read !== 1'b0 || bif.burst_write !== 1'b0) begin
               bad++;
               $display("FAIL strobe_drop: rd=%b wr=%b want 0 0", bif.burst_read, bif.burst_write);
            end
            total++;
            if (!is_wr && bif.pmem_rdata !== line) begin
               bad++;
               $display("FAIL read_line: got %h want %h", bif.pmem_rdata, line);
            end else if (is_wr && bif.pmem_rdata !== hold_val) begin
               bad++;
               $display("FAIL rdata_after_write: got %h want %h", bif.pmem_rdata, hold_val);
            end
            if (!is_wr) last_rline = line;
         end else begin
            strobe = is_wr ? bif.burst_write : bif.burst_read;
            other  = is_wr ? bif.burst_read  : bif.burst_write;
            total++;
            if (strobe !== 1'b1 || other !== 1'b0 || bif.pmem_resp !== 1'b0) begin
               bad++;
               $display("FAIL strobe: tick %0d active=%b other=%b resp=%b want 1 0 0",
                        tk, strobe, other, bif.pmem_resp);
            end
            total++;
            if (bif.burst_address !== exp_addr) begin
               bad++;
               $display("FAIL burst_address: got %h want %h", bif.burst_address, exp_addr);
            end
            if (is_wr && beats < 4) begin
               total++;
               if (bif.burst_wdata !== line[beats*64 +: 64]) begin
                  bad++;
                  $display("FAIL burst_wdata: beat %0d got %h want %h",
                           beats, bif.burst_wdata, line[beats*64 +: 64]);
               end
            end
            if (chk_hold) begin
               total++;
               if (bif.pmem_rdata !== hold_val) begin
                  bad++;
                  $display("FAIL rdata_hold: got %h want %h", bif.pmem_rdata, hold_val);
               end
            end
            if (w > 0) begin
               w--;
            end else if (beats < 4) begin
               bif.burst_resp  = 1'b1;
               bif.burst_rdata = is_wr ? {$urandom, $urandom} : line[beats*64 +: 64];
               w = gap;
            end
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL burst_timeout: no pmem_resp after %0d cycles (beats=%0d)", tk, beats);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.pmem_address = '0;
      bif.pmem_wdata   = '0;
      bif.pmem_read    = 1'b0;
      bif.pmem_write   = 1'b0;
      bif.burst_rdata  = '0;
      bif.burst_resp   = 1'b0;
      tick();
      tick();
      total++;
      if (bif.pmem_resp !== 1'b0 || bif.burst_read !== 1'b0 || bif.burst_write !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: resp=%b rd=%b wr=%b want 0 0 0",
                  bif.pmem_resp, bif.burst_read, bif.burst_write);
      end
      total++;
      if (bif.burst_address !== 32'h0 || bif.burst_wdata !== 64'h0) begin
         bad++;
         $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", bif.burst_address, bif.burst_wdata);
      end
      total++;
      if (bif.pmem_rdata !== 256'h0) begin
         bad++;
         $display("FAIL reset_rdata: got %h want 0", bif.pmem_rdata);
      end
      rst = 1'b0;
      last_rline = '0;
      tick();
   endtask

   task automatic test_read_basic();
      logic [255:0] line;
      line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      bif.pmem_address = 32'h0000_1234;
      bif.pmem_read    = 1'b1;
      run_burst(1'b0, 32'h0000_1220, line, 0, 0, 1'b0, '0, 6, 1'b0);
      bif.pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_write_gaps();
      logic [255:0] line;
      line = 256'hFFEEDDCCBBAA99887766554433221100_FFEEDDCCBBAA99887766554433221100;
      bif.pmem_address = 32'hABCD_0047;
      bif.pmem_wdata   = line;
      bif.pmem_write   = 1'b1;
      run_burst(1'b1, 32'hABCD_0040, line, 2, 0, 1'b1, last_rline, 0, 1'b0);
      bif.pmem_write = 1'b0;
      tick();
   endtask

   task automatic test_priority();
      logic [255:0] wline, rline;
      logic [31:0]  waddr, raddr;
      wline = rand256();
      rline = rand256();
      waddr = $urandom;
      raddr = $urandom;
      bif.pmem_address = waddr;
      bif.pmem_wdata   = wline;
      bif.pmem_write   = 1'b1;
      bif.pmem_read    = 1'b1;
      run_burst(1'b1, line_align(waddr), wline, $urandom_range(0, 2), 0, 1'b1, last_rline, 0, 1'b0);
      bif.pmem_write   = 1'b0;
      bif.pmem_address = raddr;
      run_burst(1'b0, line_align(raddr), rline, $urandom_range(0, 2), 1, 1'b0, '0, 0, 1'b0);
      bif.pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [255:0] line;
      logic [31:0]  addr;
      line = rand256();
      addr = $urandom;
      bif.pmem_address = $urandom;
      bif.pmem_read    = 1'b1;
      tick();
      bif.burst_resp  = 1'b1;
      bif.burst_rdata = {$urandom, $urandom};
      tick();
      bif.burst_rdata = {$urandom, $urandom};
      tick();
      bif.burst_resp = 1'b0;
      bif.pmem_read  = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (bif.burst_read !== 1'b0 || bif.pmem_resp !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_ctrl: rd=%b resp=%b want 0 0", bif.burst_read, bif.pmem_resp);
      end
      total++;
      if (bif.pmem_rdata !== 256'h0 || bif.burst_address !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid_data: rdata=%h addr=%h want 0 0", bif.pmem_rdata, bif.burst_address);
      end
      last_rline = '0;
      tick();
      bif.pmem_address = addr;
      bif.pmem_read    = 1'b1;
      run_burst(1'b0, line_align(addr), line, 0, 0, 1'b0, '0, 0, 1'b0);
      bif.pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_stray_and_addr_change();
      logic [255:0] line;
      logic [31:0]  addr;
      for (int i = 0; i < 4; i++) begin
         bif.burst_resp  = 1'b1;
         bif.burst_rdata = {$urandom, $urandom};
         tick();
         total++;
         if (bif.burst_read !== 1'b0 || bif.burst_write !== 1'b0 || bif.pmem_resp !== 1'b0 ||
             bif.pmem_rdata !== last_rline) begin
            bad++;
            $display("FAIL stray_resp: rd=%b wr=%b resp=%b rdata=%h want 0 0 0 %h",
                     bif.burst_read, bif.burst_write, bif.pmem_resp, bif.pmem_rdata, last_rline);
         end
      end
      bif.burst_resp = 1'b0;
      tick();
      line = rand256();
      addr = $urandom;
      bif.pmem_address = addr;
      bif.pmem_read    = 1'b1;
      run_burst(1'b0, line_align(addr), line, 1, 0, 1'b0, '0, 0, 1'b1);
      bif.pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [255:0] rline, wline;
      logic [31:0]  raddr, waddr;
      for (int n = 0; n < 6; n++) begin
         rline = rand256();
         wline = rand256();
         raddr = $urandom;
         waddr = $urandom;
         bif.pmem_address = raddr;
         bif.pmem_read    = 1'b1;
         run_burst(1'b0, line_align(raddr), rline, $urandom_range(0, 2), 0, 1'b0, '0, 0, 1'b0);
         bif.pmem_read = 1'b0;
         tick();
         total++;
         if (bif.pmem_resp !== 1'b0 || bif.burst_read !== 1'b0) begin
            bad++;
            $display("FAIL resp_pulse: resp=%b rd=%b want 0 0", bif.pmem_resp, bif.burst_read);
         end
         bif.pmem_address = waddr;
         bif.pmem_wdata   = wline;
         bif.pmem_write   = 1'b1;
         run_burst(1'b1, line_align(waddr), wline, $urandom_range(0, 2), 0, 1'b1, rline, 0, 1'b1);
         bif.pmem_write = 1'b0;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_gaps();
      test_priority();
      test_reset_mid();
      test_stray_and_addr_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
